// File: rtl/conv_window_mac.sv
// KxK convolution tap engine: multiply-accumulates one window of samples against the
// selected channel's weights, adds bias and applies ReLU. Optional macro: CONV_SAT_EN.
module conv_window_mac #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 10,
   parameter int K      = 3,
   parameter int NUM_CH = 8,
   parameter int ACC_W  = 32,
   localparam int KK     = K * K,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int ADDR_W = (NUM_CH * KK > 1) ? $clog2(NUM_CH * KK) : 1,
   localparam int TAP_W  = $clog2(KK + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CH_W-1:0]   ch_index,
   output logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [DATA_W-1:0] bias,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]   out_ch,
   output logic              busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] OUT   = 2'd2;

   localparam logic signed [ACC_W-1:0] MAX_POS = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);

   logic [1:0]                state;
   logic [TAP_W-1:0]          tap;
   logic signed [ACC_W-1:0]   acc;
   logic [CH_W-1:0]           ch;
   logic [CH_W-1:0]           ch_clamped;
   logic [CH_W-1:0]           addr_ch;
   logic                      beat;
   logic                      last;
   logic signed [2*DATA_W-1:0] prod_full;
   logic signed [2*DATA_W-1:0] prod_shift;
   logic signed [ACC_W-1:0]   prod;
   logic signed [ACC_W-1:0]   acc_next;
   logic signed [ACC_W-1:0]   sum;
   logic [DATA_W-1:0]         result;

   assign ch_clamped = ({1'b0, ch_index} > (CH_W + 1)'(NUM_CH - 1)) ? CH_W'(NUM_CH - 1) : ch_index;
   assign addr_ch    = (state == IDLE) ? ch_clamped : ch;
   assign w_addr     = ADDR_W'(addr_ch) * ADDR_W'(KK) + ADDR_W'(tap);

   assign in_ready  = ~reset & (state != OUT);
   assign beat      = in_valid & in_ready;
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign last      = (state == IDLE) ? (KK == 1) : (tap == TAP_W'(KK - 1));

   // Each product is floored back to the sample Q-format before it is accumulated.
   assign prod_full  = $signed(in_data) * $signed(w_data);
   assign prod_shift = prod_full >>> FRAC_W;
   assign prod       = ACC_W'(prod_shift);
   assign acc_next   = (state == IDLE) ? prod : acc + prod;
   assign sum        = acc_next + ACC_W'($signed(bias));

`ifdef CONV_SAT_EN
   always_comb begin
      result = sum[DATA_W-1:0];
      if (sum < 0)
         result = '0;
      else if (sum > MAX_POS)
         result = MAX_POS[DATA_W-1:0];
   end
`else
   // Legacy behaviour: truncate first, so an overflow into the sign bit reads as negative.
   logic unused_sum_hi;
   logic unused_max_pos;
   assign unused_sum_hi  = ^sum[ACC_W-1:DATA_W];
   assign unused_max_pos = ^MAX_POS;

   always_comb begin
      result = sum[DATA_W-1:0];
      if (sum[DATA_W-1])
         result = '0;
   end
`endif

   // Window sequencing: the first beat captures the channel, the last beat registers the result.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         tap      <= '0;
         acc      <= '0;
         ch       <= '0;
         out_data <= '0;
         out_ch   <= '0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (beat) begin
                  if (state == IDLE)
                     ch <= ch_clamped;
                  acc <= acc_next;
                  if (last) begin
                     tap      <= '0;
                     out_data <= result;
                     out_ch   <= addr_ch;
                     state    <= OUT;
                  end else begin
                     tap   <= tap + TAP_W'(1);
                     state <= ACCUM;
                  end
               end
            end
            OUT: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
